// File: rtl/uart_selftest.sv
// uart_selftest: runs a loopback self-test against a uart_top register port.
// Configures TX/RX, then for each frame loads a pattern, starts TX, polls for
// RxDone, reads RX data back, and compares it against the transmitted pattern.
// Optional macro UART_SELFTEST_LFSR_EN: when defined, patterns come from an
// 8-bit Fibonacci LFSR (taps 8,6,5,4). When undefined, each pattern is the
// previous one inverted under the data mask.
`timescale 1ns/1ps
module uart_selftest #(
  parameter int unsigned NUM_FRAMES   = 10,
  parameter logic [7:0]  SEED         = 8'hAA,
  parameter logic [1:0]  BAUD_SEL     = 2'd0,
  parameter logic [1:0]  DATA_SEL     = 2'd3,
  parameter logic [1:0]  STOP_SEL     = 2'd0,
  parameter logic        PARITY_EN    = 1'b0,
  parameter int unsigned POLL_TIMEOUT = 2_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [15:0] frame_count_o,
  output logic        wr_en_cpu_o,
  output logic        rd_en_cpu_o,
  output logic [1:0]  cpu_addr_o,
  output logic [31:0] cpu_data_o,
  input  logic [31:0] cpu_data_i
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned POLL_W = 32;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_TX     = 2'd2;
  localparam logic [1:0] ADDR_RX     = 2'd3;

  // Low (5 + DATA_SEL) bits set
  localparam logic [7:0] MASK = 8'hFF >> (3 - DATA_SEL);

  // Control word with TxEn=RxEn=1, TxStart=0; TX and RX fields share the same codes
  localparam logic [31:0] CTRL_CFG = {BAUD_SEL, 7'd0, DATA_SEL, STOP_SEL, PARITY_EN,
                                      1'b0, 1'b1, 9'd0, DATA_SEL, STOP_SEL, PARITY_EN,
                                      1'b0, 1'b1};
  localparam logic [31:0] CTRL_GO  = CTRL_CFG | 32'h0000_0002;

  localparam logic [POLL_W-1:0] POLL_LIMIT =
    (POLL_TIMEOUT == 0) ? '0 : POLL_W'(POLL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAMES_TARGET = CNT_W'(NUM_FRAMES);

`ifdef UART_SELFTEST_LFSR_EN
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
`else
  localparam logic [7:0] SEED_EFF = SEED;
`endif
  localparam logic [7:0] PAT_INIT = SEED_EFF & MASK;

  typedef enum logic [3:0] {
    IDLE, CFG_WR, LOAD_TX, START_TX, POLL_REQ, POLL_WAIT,
    RX_REQ, RX_WAIT, COMPARE, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          pattern_q, pattern_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [CNT_W-1:0]    frame_cnt_d, err_cnt_d;
  logic                timeout_d, err_inc;
  logic                busy_d, done_d, pass_d;
  logic                wr_en_d, rd_en_d;
  logic [1:0]          addr_d;
  logic [31:0]         data_d;
  logic [7:0]          pattern_adv;
`ifdef UART_SELFTEST_LFSR_EN
  logic [7:0]          lfsr_q, lfsr_d, lfsr_adv;
`endif

  // Only RxDone and the RX data byte are consumed from the read bus
  logic unused_rd_bits;
  assign unused_rd_bits = ^{cpu_data_i[31:17], cpu_data_i[15:8]};

  // Pattern advance: LFSR step or alternating inversion under the mask
`ifdef UART_SELFTEST_LFSR_EN
  always_comb begin
    lfsr_adv    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pattern_adv = lfsr_adv & MASK;
  end
`else
  always_comb begin
    pattern_adv = pattern_q ^ MASK;
  end
`endif

  // State register and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pattern_q     <= '0;
      rx_data_q     <= '0;
      poll_cnt_q    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      timeout_o     <= 1'b0;
      err_count_o   <= '0;
      frame_count_o <= '0;
      wr_en_cpu_o   <= 1'b0;
      rd_en_cpu_o   <= 1'b0;
      cpu_addr_o    <= '0;
      cpu_data_o    <= '0;
`ifdef UART_SELFTEST_LFSR_EN
      lfsr_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      rx_data_q     <= rx_data_d;
      poll_cnt_q    <= poll_cnt_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      pass_o        <= pass_d;
      timeout_o     <= timeout_d;
      err_count_o   <= err_cnt_d;
      frame_count_o <= frame_cnt_d;
      wr_en_cpu_o   <= wr_en_d;
      rd_en_cpu_o   <= rd_en_d;
      cpu_addr_o    <= addr_d;
      cpu_data_o    <= data_d;
`ifdef UART_SELFTEST_LFSR_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    rx_data_d   = rx_data_q;
    poll_cnt_d  = poll_cnt_q;
    frame_cnt_d = frame_count_o;
    err_cnt_d   = err_count_o;
    timeout_d   = timeout_o;
    err_inc     = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = '0;
    data_d      = '0;
`ifdef UART_SELFTEST_LFSR_EN
    lfsr_d      = lfsr_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = CFG_WR;
          pattern_d   = PAT_INIT;
          frame_cnt_d = '0;
          err_cnt_d   = '0;
          timeout_d   = 1'b0;
`ifdef UART_SELFTEST_LFSR_EN
          lfsr_d      = SEED_EFF;
`endif
        end
      end
      CFG_WR:   state_d = LOAD_TX;
      LOAD_TX:  state_d = START_TX;
      START_TX: begin
        state_d    = POLL_REQ;
        poll_cnt_d = '0;
      end
      POLL_REQ: begin
        state_d    = POLL_WAIT;
        poll_cnt_d = poll_cnt_q + POLL_W'(1);
      end
      POLL_WAIT: begin
        poll_cnt_d = poll_cnt_q + POLL_W'(1);
        if (cpu_data_i[16]) begin
          state_d = RX_REQ;
        end else if (poll_cnt_q >= POLL_LIMIT) begin
          state_d   = NEXT;
          timeout_d = 1'b1;
          err_inc   = 1'b1;
        end else begin
          state_d = POLL_REQ;
        end
      end
      RX_REQ:  state_d = RX_WAIT;
      RX_WAIT: begin
        rx_data_d = cpu_data_i[7:0];
        state_d   = COMPARE;
      end
      COMPARE: begin
        err_inc = ((rx_data_q & MASK) != pattern_q);
        state_d = NEXT;
      end
      NEXT: begin
        frame_cnt_d = frame_count_o + CNT_W'(1);
        pattern_d   = pattern_adv;
`ifdef UART_SELFTEST_LFSR_EN
        lfsr_d      = lfsr_adv;
`endif
        state_d     = (frame_cnt_d == FRAMES_TARGET) ? DONE : LOAD_TX;
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && (err_count_o != 16'hFFFF)) begin
      err_cnt_d = err_count_o + CNT_W'(1);
    end

    // Bus strobes are registered so they line up with the state they belong to
    case (state_d)
      CFG_WR: begin
        wr_en_d = 1'b1;
        addr_d  = ADDR_CTRL;
        data_d  = CTRL_CFG;
      end
      LOAD_TX: begin
        wr_en_d = 1'b1;
        addr_d  = ADDR_TX;
        data_d  = {24'd0, pattern_d};
      end
      START_TX: begin
        wr_en_d = 1'b1;
        addr_d  = ADDR_CTRL;
        data_d  = CTRL_GO;
      end
      POLL_REQ: begin
        rd_en_d = 1'b1;
        addr_d  = ADDR_STATUS;
      end
      RX_REQ: begin
        rd_en_d = 1'b1;
        addr_d  = ADDR_RX;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

endmodule

// File: tb/tb_uart_selftest.sv
// tb_uart_selftest: three uart_selftest instances against a behavioural
// uart_top loopback model with random RX latency and controllable corruption.
`timescale 1ns/1ps
module tb_uart_selftest;

  localparam int unsigned N   = 3;
  localparam int unsigned NF0 = 5;
  localparam int unsigned NF1 = 3;
  localparam int unsigned NF2 = 3;

  logic        tb_clk;
  logic        rst     [N];
  logic        start   [N];
  logic        busy    [N];
  logic        done    [N];
  logic        pass    [N];
  logic        tmo     [N];
  logic [15:0] errc    [N];
  logic [15:0] frc     [N];
  logic        wr_en   [N];
  logic        rd_en   [N];
  logic [1:0]  addr    [N];
  logic [31:0] wdata   [N];
  logic [31:0] rdata   [N];

  // Loopback model state
  logic [7:0]  mask     [N];
  logic [8:0]  m_tx     [N];
  logic [7:0]  m_rx     [N];
  logic        m_done   [N];
  int          m_dly    [N];
  int          m_rxidx  [N];
  bit          hold_rx0 [N];
  logic [4:0]  corrupt  [N];
  int          cbit     [N];
  logic [31:0] ctl_log0 [$];
  logic [8:0]  tx_log0  [$];
  logic [8:0]  tx_log2  [$];

  int n_assert = 0;
  int n_fail   = 0;

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  uart_selftest #(.NUM_FRAMES(NF0)) u0 (
    .clk_i(tb_clk), .rst_i(rst[0]), .start_i(start[0]), .busy_o(busy[0]),
    .done_o(done[0]), .pass_o(pass[0]), .timeout_o(tmo[0]), .err_count_o(errc[0]),
    .frame_count_o(frc[0]), .wr_en_cpu_o(wr_en[0]), .rd_en_cpu_o(rd_en[0]),
    .cpu_addr_o(addr[0]), .cpu_data_o(wdata[0]), .cpu_data_i(rdata[0]));

  uart_selftest #(.NUM_FRAMES(NF1), .POLL_TIMEOUT(100)) u1 (
    .clk_i(tb_clk), .rst_i(rst[1]), .start_i(start[1]), .busy_o(busy[1]),
    .done_o(done[1]), .pass_o(pass[1]), .timeout_o(tmo[1]), .err_count_o(errc[1]),
    .frame_count_o(frc[1]), .wr_en_cpu_o(wr_en[1]), .rd_en_cpu_o(rd_en[1]),
    .cpu_addr_o(addr[1]), .cpu_data_o(wdata[1]), .cpu_data_i(rdata[1]));

  uart_selftest #(.NUM_FRAMES(NF2), .DATA_SEL(2'd0)) u2 (
    .clk_i(tb_clk), .rst_i(rst[2]), .start_i(start[2]), .busy_o(busy[2]),
    .done_o(done[2]), .pass_o(pass[2]), .timeout_o(tmo[2]), .err_count_o(errc[2]),
    .frame_count_o(frc[2]), .wr_en_cpu_o(wr_en[2]), .rd_en_cpu_o(rd_en[2]),
    .cpu_addr_o(addr[2]), .cpu_data_o(wdata[2]), .cpu_data_i(rdata[2]));

  // Behavioural uart_top: loops TX data back after a random latency, 1-cycle reads
  always @(posedge tb_clk) begin
    for (int i = 0; i < int'(N); i++) begin
      logic [7:0] flip;
      if (rst[i]) begin
        m_done[i]  <= 1'b0;
        m_dly[i]   <= 0;
        m_rxidx[i] <= 0;
        rdata[i]   <= '0;
      end else begin
        flip = '0;
        if (start[i] && !busy[i]) m_rxidx[i] <= 0;
        if (wr_en[i] && addr[i] == 2'd2) begin
          m_tx[i] <= wdata[i][8:0];
          if (i == 0) tx_log0.push_back(wdata[i][8:0]);
          if (i == 2) tx_log2.push_back(wdata[i][8:0]);
        end
        if (wr_en[i] && addr[i] == 2'd1) begin
          if (i == 0) ctl_log0.push_back(wdata[i]);
          if (wdata[i][1]) m_dly[i] <= int'($urandom_range(40, 3));
        end else if (m_dly[i] > 0) begin
          m_dly[i] <= m_dly[i] - 1;
          if (m_dly[i] == 1) begin
            m_done[i] <= !hold_rx0[i];
            m_rx[i]   <= m_tx[i][7:0] & mask[i];
          end
        end
        if (rd_en[i]) begin
          if (addr[i] == 2'd3) begin
            if (m_rxidx[i] < 5 && corrupt[i][m_rxidx[i]]) flip = 8'h01 << cbit[i];
            rdata[i]   <= {24'd0, m_rx[i] ^ flip};
            m_done[i]  <= 1'b0;
            m_rxidx[i] <= m_rxidx[i] + 1;
          end else if (addr[i] == 2'd0) begin
            rdata[i] <= {15'd0, m_done[i], 16'd0};
          end else begin
            rdata[i] <= '0;
          end
        end else begin
          rdata[i] <= $urandom();
        end
      end
    end
  end

  // Reference: alternating inversion of the masked seed
  function automatic logic [7:0] ref_pattern(input logic [7:0] seed, input logic [7:0] m,
                                             input int k);
    return (k % 2 == 0) ? (seed & m) : (~seed & m);
  endfunction

  // Reference: control word assembled from its fields
  function automatic logic [31:0] ref_ctrl(input int baud, input int data, input int stop,
                                           input int par, input int go);
    longint w;
    w = (longint'(baud) << 30) | (longint'(data) << 21) | (longint'(stop) << 19) |
        (longint'(par) << 18) | (longint'(1) << 16) | (longint'(data) << 5) |
        (longint'(stop) << 3) | (longint'(par) << 2) | (longint'(go) << 1) | longint'(1);
    return w[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    check($sformatf("%s_busy%0d", tag, i),  32'(busy[i]),  32'd0);
    check($sformatf("%s_done%0d", tag, i),  32'(done[i]),  32'd0);
    check($sformatf("%s_pass%0d", tag, i),  32'(pass[i]),  32'd0);
    check($sformatf("%s_tmo%0d", tag, i),   32'(tmo[i]),   32'd0);
    check($sformatf("%s_err%0d", tag, i),   32'(errc[i]),  32'd0);
    check($sformatf("%s_frm%0d", tag, i),   32'(frc[i]),   32'd0);
    check($sformatf("%s_wr%0d", tag, i),    32'(wr_en[i]), 32'd0);
    check($sformatf("%s_rd%0d", tag, i),    32'(rd_en[i]), 32'd0);
    check($sformatf("%s_addr%0d", tag, i),  32'(addr[i]),  32'd0);
    check($sformatf("%s_wdata%0d", tag, i), wdata[i],      32'd0);
  endtask

  // Start a run, optionally poke start again mid-run, wait for done within budget
  task automatic run(input int i, input int budget, input int poke);
    int cyc = 0;
    @(negedge tb_clk) start[i] = 1'b1;
    @(negedge tb_clk) start[i] = 1'b0;
    check($sformatf("busy_after_start%0d", i), 32'(busy[i]), 32'd1);
    check($sformatf("done_clr_on_start%0d", i), 32'(done[i]), 32'd0);
    while (!done[i] && cyc < budget) begin
      start[i] = (cyc == poke);
      @(negedge tb_clk);
      cyc++;
    end
    start[i] = 1'b0;
    check($sformatf("done_in_budget%0d", i), 32'(done[i]), 32'd1);
  endtask

  task automatic check_result(input int i, input string tag, input int e_err,
                              input int e_frm, input bit e_tmo);
    check({tag, "_done"}, 32'(done[i]), 32'd1);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
    check({tag, "_err"},  32'(errc[i]), 32'(e_err));
    check({tag, "_frm"},  32'(frc[i]),  32'(e_frm));
    check({tag, "_tmo"},  32'(tmo[i]),  32'(e_tmo));
    check({tag, "_pass"}, 32'(pass[i]), 32'(e_err == 0));
  endtask

  initial begin
    int e_err;
    int cyc;
    for (int i = 0; i < int'(N); i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; hold_rx0[i] = 1'b0; corrupt[i] = '0; cbit[i] = 0;
    end
    mask[0] = 8'hFF; mask[1] = 8'hFF; mask[2] = 8'h1F;
    repeat (3) @(negedge tb_clk);
    for (int i = 0; i < int'(N); i++) check_idle(i, "reset");
    for (int i = 0; i < int'(N); i++) rst[i] = 1'b0;
    repeat (2) @(negedge tb_clk);

    // Clean loopback run: patterns and control words
    ctl_log0.delete(); tx_log0.delete();
    run(0, 3000, -1);
    check_result(0, "clean", 0, int'(NF0), 1'b0);
    check("tx_count", 32'(tx_log0.size()), 32'(NF0));
    for (int k = 0; k < int'(NF0); k++)
      check($sformatf("tx_pat%0d", k), 32'(tx_log0[k]), 32'(ref_pattern(8'hAA, 8'hFF, k)));
    check("ctl_count", 32'(ctl_log0.size()), 32'(NF0 + 1));
    check("ctl_cfg", ctl_log0[0], ref_ctrl(0, 3, 0, 0, 0));
    check("ctl_go",  ctl_log0[1], ref_ctrl(0, 3, 0, 0, 1));

    // Bit 0 flipped on the second frame's RX read
    corrupt[0] = 5'b00010; cbit[0] = 0;
    run(0, 3000, -1);
    check_result(0, "flip_f2", 1, int'(NF0), 1'b0);

    // Random corruption plus an ignored start while busy
    for (int r = 0; r < 4; r++) begin
      corrupt[0] = 5'($urandom());
      cbit[0]    = int'($urandom_range(7, 0));
      e_err      = $countones(corrupt[0]);
      run(0, 3000, int'($urandom_range(40, 2)));
      check_result(0, $sformatf("rand%0d", r), e_err, int'(NF0), 1'b0);
    end
    corrupt[0] = '0;

    // RxDone never asserted: every frame times out
    hold_rx0[1] = 1'b1;
    run(1, 3000, -1);
    check_result(1, "timeout", int'(NF1), int'(NF1), 1'b1);

    // Five-bit data width
    tx_log2.delete();
    run(2, 3000, -1);
    check_result(2, "data5", 0, int'(NF2), 1'b0);
    check("d5_count", 32'(tx_log2.size()), 32'(NF2));
    for (int k = 0; k < int'(NF2); k++)
      check($sformatf("d5_pat%0d", k), 32'(tx_log2[k]), 32'(ref_pattern(8'hAA, 8'h1F, k)));

    // Reset during the third frame, then a clean restart
    @(negedge tb_clk) start[0] = 1'b1;
    @(negedge tb_clk) start[0] = 1'b0;
    cyc = 0;
    while (frc[0] != 16'd2 && cyc < 3000) begin
      @(negedge tb_clk);
      cyc++;
    end
    check("reach_frame3", 32'(frc[0]), 32'd2);
    repeat ($urandom_range(4, 0)) @(negedge tb_clk);
    rst[0] = 1'b1;
    #1;
    check_idle(0, "midrst");
    repeat (2) @(negedge tb_clk);
    rst[0] = 1'b0;
    repeat (20) @(negedge tb_clk);
    check("no_resume_busy", 32'(busy[0]), 32'd0);
    check("no_resume_done", 32'(done[0]), 32'd0);
    run(0, 3000, -1);
    check_result(0, "restart", 0, int'(NF0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
